// File: rtl/dcache_ctrl.sv
// dcache_ctrl: direct-mapped, write-back, write-allocate data cache controller.
//
// Serves one CPU request at a time. Hits complete in the cycle after accept.
// Misses first write back a dirty victim line, then fill the line from backing
// memory one beat per mem_ack, and finally complete through a second lookup.
//
// Ports
//   clk, reset           clock; asynchronous active-low reset
//   cpu_valid/addr/din   CPU request, address (byte, [1:0] ignored), store data
//   cpu_mem_read/write   request opcode (both set means store)
//   cpu_ready            request accepted when high together with cpu_valid
//   cpu_resp_valid       one-cycle completion pulse
//   cpu_dout/cpu_hit     load data and first-lookup-hit flag, with cpu_resp_valid
//   mem_req/write/addr/din  backing-memory beat, held until mem_ack
//   mem_ack/mem_dout     beat completion and read data

module dcache_ctrl #(
    parameter int unsigned NUM_LINES  = 16,
    parameter int unsigned LINE_WORDS = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_valid,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_din,
    input  logic        cpu_mem_read,
    input  logic        cpu_mem_write,
    output logic        cpu_ready,
    output logic        cpu_resp_valid,
    output logic [31:0] cpu_dout,
    output logic        cpu_hit,
    output logic        mem_req,
    output logic        mem_write,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_din,
    input  logic        mem_ack,
    input  logic [31:0] mem_dout
);

    localparam int unsigned OFF_W = $clog2(LINE_WORDS);
    localparam int unsigned IDX_W = $clog2(NUM_LINES);
    localparam int unsigned TAG_W = 32 - 2 - OFF_W - IDX_W;
    localparam int unsigned DEPTH = NUM_LINES * LINE_WORDS;
    localparam int unsigned DIDX_W = IDX_W + OFF_W;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        COMPARE   = 2'd1,
        WRITEBACK = 2'd2,
        ALLOCATE  = 2'd3
    } state_t;

    // Control state
    state_t             state_q, state_d;
    logic [OFF_W-1:0]   beat_q, beat_d;
    logic [29:0]        addr_q, addr_d;     // latched word address
    logic [31:0]        din_q, din_d;
    logic               store_q, store_d;
    logic               miss_q, miss_d;     // request already missed once
    logic [NUM_LINES-1:0] valid_q, valid_d;
    logic [NUM_LINES-1:0] dirty_q, dirty_d;

    // Storage arrays (not reset)
    logic [31:0]        data_q [DEPTH];
    logic [TAG_W-1:0]   tag_q  [NUM_LINES];

    logic               data_we;
    logic [DIDX_W-1:0]  data_widx;
    logic [31:0]        data_wdata;
    logic               tag_we;

    // Byte-lane bits of the CPU address carry no meaning here
    logic unused_addr_bits;
    assign unused_addr_bits = ^cpu_addr[1:0];

    // Request address fields
    logic [OFF_W-1:0] req_off;
    logic [IDX_W-1:0] req_idx;
    logic [TAG_W-1:0] req_tag;
    assign req_off = addr_q[OFF_W-1:0];
    assign req_idx = addr_q[OFF_W+IDX_W-1:OFF_W];
    assign req_tag = addr_q[29:OFF_W+IDX_W];

    // Lookup of the indexed line
    logic [TAG_W-1:0] cur_tag;
    logic             hit_c;
    logic [31:0]      hit_word;
    logic [31:0]      wb_word;
    assign cur_tag  = tag_q[req_idx];
    assign hit_c    = valid_q[req_idx] && (cur_tag == req_tag);
    assign hit_word = data_q[{req_idx, req_off}];
    assign wb_word  = data_q[{req_idx, beat_q}];

    // Ready is a pure function of state, gated so it reads 0 while in reset
    assign cpu_ready = reset && (state_q == IDLE);

    // Next-state, storage write and output logic
    always_comb begin
        state_d        = state_q;
        beat_d         = beat_q;
        addr_d         = addr_q;
        din_d          = din_q;
        store_d        = store_q;
        miss_d         = miss_q;
        valid_d        = valid_q;
        dirty_d        = dirty_q;
        data_we        = 1'b0;
        data_widx      = {req_idx, req_off};
        data_wdata     = din_q;
        tag_we         = 1'b0;
        cpu_resp_valid = 1'b0;
        cpu_dout       = 32'd0;
        cpu_hit        = 1'b0;
        mem_req        = 1'b0;
        mem_write      = 1'b0;
        mem_addr       = 32'd0;
        mem_din        = 32'd0;

        unique case (state_q)
            IDLE: begin
                if (cpu_valid && (cpu_mem_read || cpu_mem_write)) begin
                    addr_d  = cpu_addr[31:2];
                    din_d   = cpu_din;
                    store_d = cpu_mem_write;
                    miss_d  = 1'b0;
                    state_d = COMPARE;
                end
            end

            COMPARE: begin
                if (hit_c) begin
                    cpu_resp_valid = 1'b1;
                    cpu_hit        = !miss_q;
                    if (store_q) begin
                        data_we          = 1'b1;
                        dirty_d[req_idx] = 1'b1;
                    end else begin
                        cpu_dout = hit_word;
                    end
                    state_d = IDLE;
                end else begin
                    miss_d  = 1'b1;
                    beat_d  = '0;
                    state_d = (valid_q[req_idx] && dirty_q[req_idx]) ? WRITEBACK : ALLOCATE;
                end
            end

            WRITEBACK: begin
                mem_req   = 1'b1;
                mem_write = 1'b1;
                mem_addr  = {cur_tag, req_idx, beat_q, 2'b00};
                mem_din   = wb_word;
                if (mem_ack) begin
                    if (beat_q == OFF_W'(LINE_WORDS - 1)) begin
                        beat_d  = '0;
                        state_d = ALLOCATE;
                    end else begin
                        beat_d = beat_q + OFF_W'(1);
                    end
                end
            end

            ALLOCATE: begin
                mem_req  = 1'b1;
                mem_addr = {req_tag, req_idx, beat_q, 2'b00};
                if (mem_ack) begin
                    data_we    = 1'b1;
                    data_widx  = {req_idx, beat_q};
                    data_wdata = mem_dout;
                    if (beat_q == OFF_W'(LINE_WORDS - 1)) begin
                        tag_we           = 1'b1;
                        valid_d[req_idx] = 1'b1;
                        dirty_d[req_idx] = 1'b0;
                        beat_d           = '0;
                        state_d          = COMPARE;
                    end else begin
                        beat_d = beat_q + OFF_W'(1);
                    end
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // Control registers; reset abandons any in-flight request
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            beat_q  <= '0;
            addr_q  <= '0;
            din_q   <= '0;
            store_q <= 1'b0;
            miss_q  <= 1'b0;
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
            store_q <= store_d;
            miss_q  <= miss_d;
            valid_q <= valid_d;
            dirty_q <= dirty_d;
        end
    end

    // Data and tag arrays; contents are qualified by valid bits
    always_ff @(posedge clk) begin
        if (data_we) begin
            data_q[data_widx] <= data_wdata;
        end
        if (tag_we) begin
            tag_q[req_idx] <= req_tag;
        end
    end

endmodule

// File: tb/tb_dcache_ctrl.sv
// tb_dcache_ctrl: directed bench for dcache_ctrl with a backing-memory model
// that acknowledges each beat two cycles after it is requested.

module tb_dcache_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_valid;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_din;
    logic        cpu_mem_read;
    logic        cpu_mem_write;
    logic        cpu_ready;
    logic        cpu_resp_valid;
    logic [31:0] cpu_dout;
    logic        cpu_hit;
    logic        mem_req;
    logic        mem_write;
    logic [31:0] mem_addr;
    logic [31:0] mem_din;
    logic        mem_ack;
    logic [31:0] mem_dout;

    logic        model_ack;
    logic        force_ack;
    assign mem_ack = model_ack | force_ack;

    always #5 clk = ~clk;

    dcache_ctrl #(.NUM_LINES(16), .LINE_WORDS(4)) dut (
        .clk            (clk),
        .reset          (reset),
        .cpu_valid      (cpu_valid),
        .cpu_addr       (cpu_addr),
        .cpu_din        (cpu_din),
        .cpu_mem_read   (cpu_mem_read),
        .cpu_mem_write  (cpu_mem_write),
        .cpu_ready      (cpu_ready),
        .cpu_resp_valid (cpu_resp_valid),
        .cpu_dout       (cpu_dout),
        .cpu_hit        (cpu_hit),
        .mem_req        (mem_req),
        .mem_write      (mem_write),
        .mem_addr       (mem_addr),
        .mem_din        (mem_din),
        .mem_ack        (mem_ack),
        .mem_dout       (mem_dout)
    );

    typedef struct {
        logic        w;
        logic [31:0] a;
        logic [31:0] d;
    } beat_t;

    beat_t       beat_log[$];
    logic [31:0] mem_arr [1024];

    int passed = 0;
    int total  = 0;

    // Backing memory: word i holds 0xC0000000|i, except 0x100..0x10C = 0xA0+i
    initial begin
        int cnt;
        logic [9:0] widx;
        for (int i = 0; i < 1024; i++) mem_arr[i] = 32'hC000_0000 | 32'(i);
        for (int i = 0; i < 4; i++) mem_arr[64 + i] = 32'hA0 + 32'(i);
        model_ack = 1'b0;
        mem_dout  = 32'd0;
        cnt       = 0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                cnt       = 0;
                model_ack = 1'b0;
            end else if (model_ack) begin
                model_ack = 1'b0;
                cnt       = mem_req ? 1 : 0;
            end else if (mem_req) begin
                cnt = cnt + 1;
                if (cnt >= 2) begin
                    cnt       = 0;
                    model_ack = 1'b1;
                    widx      = mem_addr[11:2];
                    if (mem_write) begin
                        mem_arr[widx] = mem_din;
                        mem_dout      = 32'd0;
                        beat_log.push_back('{w: 1'b1, a: mem_addr, d: mem_din});
                    end else begin
                        mem_dout = mem_arr[widx];
                        beat_log.push_back('{w: 1'b0, a: mem_addr, d: mem_arr[widx]});
                    end
                end
            end else begin
                cnt = 0;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    endtask

    // Issue one request and wait (bounded) for its completion pulse
    task automatic run_req(input string tag, input logic [31:0] a, input logic [31:0] d,
                           input logic rd, input logic wr,
                           output logic [31:0] dout, output logic hit,
                           output int lat, output int nb);
        int base;
        @(negedge clk); #1;
        chk({tag, "_ready"}, 32'(cpu_ready), 32'd1);
        base          = beat_log.size();
        cpu_valid     = 1'b1;
        cpu_addr      = a;
        cpu_din       = d;
        cpu_mem_read  = rd;
        cpu_mem_write = wr;
        @(posedge clk); #1;
        cpu_valid     = 1'b0;
        cpu_mem_read  = 1'b0;
        cpu_mem_write = 1'b0;
        cpu_addr      = 32'hFFFF_FFFF;
        cpu_din       = 32'hFFFF_FFFF;
        lat  = 0;
        dout = 32'hXXXX_XXXX;
        hit  = 1'bx;
        for (int i = 1; i <= 200; i++) begin
            @(negedge clk); #1;
            if (cpu_resp_valid) begin
                lat  = i;
                dout = cpu_dout;
                hit  = cpu_hit;
                break;
            end
        end
        nb = beat_log.size() - base;
    endtask

    initial begin
        logic [31:0] dout;
        logic        hit;
        int          lat;
        int          nb;
        int          base;
        int          resp_seen;
        logic [31:0] exp_wb [4];

        exp_wb[0] = 32'hA0;
        exp_wb[1] = 32'hDEAD_BEEF;
        exp_wb[2] = 32'hA2;
        exp_wb[3] = 32'hA3;

        reset         = 1'b0;
        cpu_valid     = 1'b0;
        cpu_addr      = 32'd0;
        cpu_din       = 32'd0;
        cpu_mem_read  = 1'b0;
        cpu_mem_write = 1'b0;
        force_ack     = 1'b0;

        // Outputs while held in reset
        repeat (3) @(negedge clk);
        #1;
        chk("rst_ready", 32'(cpu_ready), 32'd0);
        chk("rst_resp", 32'(cpu_resp_valid), 32'd0);
        chk("rst_dout", cpu_dout, 32'd0);
        chk("rst_hit", 32'(cpu_hit), 32'd0);
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_mem_write", 32'(mem_write), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_din", mem_din, 32'd0);

        // Ready before the first posedge after release
        reset = 1'b1;
        #1;
        chk("rel_ready", 32'(cpu_ready), 32'd1);

        // Stray mem_ack in IDLE is ignored
        @(negedge clk); #1;
        force_ack = 1'b1;
        @(posedge clk); #1;
        force_ack = 1'b0;
        @(negedge clk); #1;
        chk("stray_ack_ready", 32'(cpu_ready), 32'd1);
        chk("stray_ack_mem_req", 32'(mem_req), 32'd0);

        // Cold load 0x100: four read beats, then completion without hit
        base = beat_log.size();
        run_req("cold", 32'h100, 32'd0, 1'b1, 1'b0, dout, hit, lat, nb);
        chk("cold_lat", 32'(lat), 32'd10);
        chk("cold_dout", dout, 32'hA0);
        chk("cold_hit", 32'(hit), 32'd0);
        chk("cold_nbeats", 32'(nb), 32'd4);
        for (int i = 0; i < 4 && i < nb; i++) begin
            chk("cold_beat_w", 32'(beat_log[base + i].w), 32'd0);
            chk("cold_beat_a", beat_log[base + i].a, 32'h100 + 32'(4 * i));
        end

        // Load 0x108: one-cycle hit, no memory traffic
        run_req("hit108", 32'h108, 32'd0, 1'b1, 1'b0, dout, hit, lat, nb);
        chk("hit108_lat", 32'(lat), 32'd1);
        chk("hit108_dout", dout, 32'hA2);
        chk("hit108_hit", 32'(hit), 32'd1);
        chk("hit108_nbeats", 32'(nb), 32'd0);

        // Store hit to 0x104 makes line 0 dirty
        run_req("st104", 32'h104, 32'hDEAD_BEEF, 1'b0, 1'b1, dout, hit, lat, nb);
        chk("st104_lat", 32'(lat), 32'd1);
        chk("st104_dout", dout, 32'd0);
        chk("st104_hit", 32'(hit), 32'd1);
        chk("st104_nbeats", 32'(nb), 32'd0);

        // Conflicting load 0x504: write back dirty line, then refill
        base = beat_log.size();
        run_req("ld504", 32'h504, 32'd0, 1'b1, 1'b0, dout, hit, lat, nb);
        chk("ld504_lat", 32'(lat), 32'd18);
        chk("ld504_nbeats", 32'(nb), 32'd8);
        chk("ld504_dout", dout, 32'hC000_0141);
        chk("ld504_hit", 32'(hit), 32'd0);
        for (int i = 0; i < 8 && i < nb; i++) begin
            if (i < 4) begin
                chk("wb_beat_w", 32'(beat_log[base + i].w), 32'd1);
                chk("wb_beat_a", beat_log[base + i].a, 32'h100 + 32'(4 * i));
                chk("wb_beat_d", beat_log[base + i].d, exp_wb[i]);
            end else begin
                chk("fill_beat_w", 32'(beat_log[base + i].w), 32'd0);
                chk("fill_beat_a", beat_log[base + i].a, 32'h500 + 32'(4 * (i - 4)));
            end
        end

        // Both opcodes set: treated as store (clean victim, fill only)
        base = beat_log.size();
        run_req("both200", 32'h200, 32'h55, 1'b1, 1'b1, dout, hit, lat, nb);
        chk("both200_lat", 32'(lat), 32'd10);
        chk("both200_dout", dout, 32'd0);
        chk("both200_hit", 32'(hit), 32'd0);
        chk("both200_nbeats", 32'(nb), 32'd4);
        if (nb > 0) chk("both200_first_a", beat_log[base].a, 32'h200);
        if (nb > 0) chk("both200_first_w", 32'(beat_log[base].w), 32'd0);

        run_req("ld200", 32'h200, 32'd0, 1'b1, 1'b0, dout, hit, lat, nb);
        chk("ld200_lat", 32'(lat), 32'd1);
        chk("ld200_dout", dout, 32'h55);
        chk("ld200_hit", 32'(hit), 32'd1);

        // Reset during the second allocate beat of load 0x340
        @(negedge clk); #1;
        chk("rst340_ready", 32'(cpu_ready), 32'd1);
        base          = beat_log.size();
        cpu_valid     = 1'b1;
        cpu_addr      = 32'h340;
        cpu_mem_read  = 1'b1;
        cpu_mem_write = 1'b0;
        @(posedge clk); #1;
        cpu_valid    = 1'b0;
        cpu_mem_read = 1'b0;
        resp_seen    = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk); #1;
            if (cpu_resp_valid) resp_seen++;
            if (beat_log.size() >= base + 1) break;
        end
        chk("rst340_first_beat", 32'(beat_log.size() - base), 32'd1);
        @(posedge clk); #2;
        chk("rst340_beat2_req", 32'(mem_req), 32'd1);
        chk("rst340_beat2_addr", mem_addr, 32'h344);
        reset = 1'b0;
        #1;
        chk("rst340_req_drop", 32'(mem_req), 32'd0);
        chk("rst340_addr_zero", mem_addr, 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            if (cpu_resp_valid) resp_seen++;
        end
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            if (cpu_resp_valid) resp_seen++;
        end
        chk("rst340_no_resp", 32'(resp_seen), 32'd0);

        // Same address misses again after reset
        run_req("ld340", 32'h340, 32'd0, 1'b1, 1'b0, dout, hit, lat, nb);
        chk("ld340_lat", 32'(lat), 32'd10);
        chk("ld340_hit", 32'(hit), 32'd0);
        chk("ld340_dout", dout, 32'hC000_00D0);
        chk("ld340_nbeats", 32'(nb), 32'd4);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/dcache_ctrl.md
DCACHE_CTRL -- requirements
Module: dcache_ctrl

Interface
REQ-001 SHALL have parameter NUM_LINES, default 16, number of direct-mapped lines (power of 2, 4..256).
REQ-002 SHALL have parameter LINE_WORDS, default 4, 32-bit words per line (power of 2, 2..8).
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on posedge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port cpu_valid  input  1  request present.
REQ-006 SHALL have port cpu_addr  input  32  byte address; bits [1:0] ignored.
REQ-007 SHALL have port cpu_din  input  32  store data.
REQ-008 SHALL have port cpu_mem_read  input  1  load request.
REQ-009 SHALL have port cpu_mem_write  input  1  store request.
REQ-010 SHALL have port cpu_ready  output  1  request accepted this cycle when high with cpu_valid.
REQ-011 SHALL have port cpu_resp_valid  output  1  one-cycle completion pulse.
REQ-012 SHALL have port cpu_dout  output  32  load data, valid with cpu_resp_valid.
REQ-013 SHALL have port cpu_hit  output  1  completion was a first-lookup hit, valid with cpu_resp_valid.
REQ-014 SHALL have port mem_req  output  1  backing-memory beat request.
REQ-015 SHALL have port mem_write  output  1  beat is a write (1) or read (0).
REQ-016 SHALL have port mem_addr  output  32  word-aligned byte address of beat.
REQ-017 SHALL have port mem_din  output  32  write data of beat.
REQ-018 SHALL have port mem_ack  input  1  beat complete; mem_dout valid same cycle on reads.
REQ-019 SHALL have port mem_dout  input  32  read data from backing memory.

Function
REQ-020 SHALL split the address: offset = addr[log2(LINE_WORDS)+1:2], index = next log2(NUM_LINES) bits, tag = remaining upper bits.
REQ-021 SHALL hold per line a valid bit, dirty bit, tag and LINE_WORDS data words; write-back, write-allocate.
REQ-022 SHALL implement FSM states IDLE, COMPARE, WRITEBACK, ALLOCATE.
REQ-023 SHALL assert cpu_ready only in IDLE; accept when cpu_valid && (cpu_mem_read || cpu_mem_write); latch addr/din/op; go COMPARE.
REQ-024 SHALL ignore cpu_valid with neither op set; with both set SHALL treat the request as a store.
REQ-025 COMPARE hit (valid && tag match): SHALL pulse cpu_resp_valid, drive word on cpu_dout for loads, write word and set dirty for stores, return IDLE; hit latency = 1 cycle after accept.
REQ-026 COMPARE miss: SHALL go WRITEBACK if victim valid && dirty, else ALLOCATE.
REQ-027 WRITEBACK SHALL issue LINE_WORDS write beats, word 0 first, at victim tag/index address; then ALLOCATE.
REQ-028 ALLOCATE SHALL issue LINE_WORDS read beats, word 0 first, fill line, set valid, clear dirty, set tag; then COMPARE.
REQ-029 the post-fill COMPARE SHALL hit and complete with cpu_hit = 0.
REQ-030 SHALL hold mem_req, mem_write, mem_addr, mem_din stable until mem_ack; one beat per ack; next beat may start the cycle after ack.
REQ-031 SHALL ignore mem_ack while mem_req is low.
REQ-032 SHALL keep mem_req low in IDLE and COMPARE; cpu_resp_valid low outside COMPARE.
REQ-033 cpu_dout SHALL be 0 when cpu_resp_valid is low or the op is a store.
REQ-034 SHALL serve exactly one outstanding request; cpu inputs are don't-care after accept.

Reset
REQ-035 reset low SHALL immediately force IDLE, clear all valid and dirty bits, beat counter to 0.
REQ-036 while reset low SHALL drive cpu_ready=0, cpu_resp_valid=0, cpu_dout=0, cpu_hit=0, mem_req=0, mem_write=0, mem_addr=0, mem_din=0.
REQ-037 reset mid-burst SHALL abandon the burst and the request with no completion pulse; data arrays need not be cleared.
REQ-038 first posedge after reset release SHALL see cpu_ready=1.

Verification
REQ-039 cold load 0x100, mem returns 0xA0+i on beat i, ack 2 cycles after req -> 4 read beats at 0x100..0x10C, cpu_dout=0xA0, cpu_hit=0.
REQ-040 load 0x108 after REQ-039 -> cpu_resp_valid 1 cycle after accept, cpu_dout=0xA2, cpu_hit=1, mem_req never high.
REQ-041 store 0xDEADBEEF to 0x104, then load 0x504 (same index 0) -> 4 write beats 0x100..0x10C with word1=0xDEADBEEF, then 4 reads at 0x500..0x50C.
REQ-042 cpu_valid with both ops high, addr 0x200, din 0x55 -> treated as store; later load 0x200 returns 0x55, cpu_dout=0 on store completion.
REQ-043 reset asserted during 2nd allocate beat -> mem_req drops asynchronously, no cpu_resp_valid, later load same address misses.
REQ-044 mem_ack pulses with mem_req low in IDLE -> no state change, cpu_ready stays 1.
